// File: rtl/module_display_scan.sv
// Captures a/b/m on load strobes, converts to BCD by sequential double-dabble,
// and scans the result onto a 4-digit common-anode seven-segment display.
module module_display_scan #(
  parameter int unsigned REFRESH_CYCLES = 27000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_a,
  input  logic       load_b,
  input  logic       load_m,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [7:0] m,
  output logic [3:0] anodo,
  output logic [6:0] catodo,
  output logic       conv_busy
);

  localparam int unsigned CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_A, SRC_B, SRC_P} src_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_bin;
  logic [11:0] r_bcd, w_adj;
  logic [2:0]  r_iter;
  src_t        r_pend, r_disp_src, w_load_src, w_src_show;
  logic [11:0] r_disp_bcd, w_bcd_show;
  logic [7:0]  w_load_val;
  logic        w_strobe, w_disp_upd;
  logic [CW-1:0] r_cnt;
  logic [1:0]  r_dig;
  logic [6:0]  w_seg;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = 7'b1111111;
    endcase
  endfunction

  assign w_strobe = load_a | load_b | load_m;

  always_comb begin
    w_load_val = '0;
    w_load_src = SRC_NONE;
    if (load_m) begin
      w_load_val = m;
      w_load_src = SRC_P;
    end else if (load_b) begin
      w_load_val = {4'b0000, b};
      w_load_src = SRC_B;
    end else if (load_a) begin
      w_load_val = {4'b0000, a};
      w_load_src = SRC_A;
    end
  end

  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A strobe always restarts; a strobe landing in DONE drops the finished result.
  always_comb begin
    w_state_nxt = r_state;
    w_disp_upd  = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_strobe) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (w_strobe)              w_state_nxt = ST_SHIFT;
        else if (r_iter == 3'd7)   w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (w_strobe) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
          w_disp_upd  = 1'b1;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign conv_busy = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_iter     <= '0;
      r_pend     <= SRC_NONE;
      r_disp_bcd <= '0;
      r_disp_src <= SRC_NONE;
    end else if (w_strobe) begin
      r_bin  <= w_load_val;
      r_bcd  <= '0;
      r_iter <= '0;
      r_pend <= w_load_src;
    end else begin
      if (r_state == ST_SHIFT) begin
        {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
        r_iter         <= r_iter + 3'd1;
      end
      if (w_disp_upd) begin
        r_disp_bcd <= r_bcd;
        r_disp_src <= r_pend;
      end
    end
  end

  // Segments are decoded from the value the display registers take this edge,
  // so a finished conversion is visible on the same edge it is committed.
  assign w_bcd_show = w_disp_upd ? r_bcd  : r_disp_bcd;
  assign w_src_show = w_disp_upd ? r_pend : r_disp_src;

  always_comb begin
    w_seg = 7'b1111111;
    case (r_dig)
      2'd0: w_seg = f_seg(w_bcd_show[3:0]);
      2'd1: if (w_bcd_show[11:4] != 8'd0) w_seg = f_seg(w_bcd_show[7:4]);
      2'd2: if (w_bcd_show[11:8] != 4'd0) w_seg = f_seg(w_bcd_show[11:8]);
      default: begin
        case (w_src_show)
          SRC_A:   w_seg = 7'b0001000;
          SRC_B:   w_seg = 7'b0000011;
          SRC_P:   w_seg = 7'b0001100;
          default: w_seg = 7'b1111111;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_dig  <= '0;
      anodo  <= '1;
      catodo <= '1;
    end else begin
      anodo  <= ~(4'b0001 << r_dig);
      catodo <= w_seg;
      if (r_cnt == CW'(REFRESH_CYCLES - 1)) begin
        r_cnt <= '0;
        r_dig <= r_dig + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_module_display_scan.sv
// Bench for module_display_scan: decimal/scan-time reference model checked every
// cycle, plus literal per-digit segment expectations.
module tb_module_display_scan;

  localparam int unsigned R = 4;

  logic       clk = 1'b0;
  logic       rst, load_a, load_b, load_m;
  logic [3:0] a, b;
  logic [7:0] m;
  logic [3:0] anodo;
  logic [6:0] catodo;
  logic       conv_busy;

  int checks = 0;
  int errors = 0;

  module_display_scan #(.REFRESH_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .load_a(load_a), .load_b(load_b), .load_m(load_m),
    .a(a), .b(b), .m(m), .anodo(anodo), .catodo(catodo), .conv_busy(conv_busy)
  );

  always #5 clk = ~clk;

  logic [6:0] DIG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Model: decimal value/source on display, countdown of the pending conversion,
  // and the lit digit derived from the number of edges since reset.
  int         dv, ds, pv, ps, cd, mcyc;
  bit         mvalid = 0;
  logic [3:0] e_an;
  logic [6:0] e_cat;
  logic       e_busy;

  function automatic logic [6:0] m_seg(input int d, input int v, input int src);
    int h, t, u;
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    case (d)
      0: return DIG[u];
      1: return (h == 0 && t == 0) ? 7'b1111111 : DIG[t];
      2: return (h == 0) ? 7'b1111111 : DIG[h];
      default: case (src)
        1: return 7'b0001000;
        2: return 7'b0000011;
        3: return 7'b0001100;
        default: return 7'b1111111;
      endcase
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      dv = 0; ds = 0; pv = 0; ps = 0; cd = 0; mcyc = 0;
      e_an = 4'b1111; e_cat = 7'b1111111; e_busy = 1'b0;
      mvalid = 1;
    end else begin
      int d;
      mcyc++;
      if (load_m)      begin pv = int'(m); ps = 3; cd = 9; end
      else if (load_b) begin pv = int'(b); ps = 2; cd = 9; end
      else if (load_a) begin pv = int'(a); ps = 1; cd = 9; end
      else if (cd > 0) begin
        cd--;
        if (cd == 0) begin dv = pv; ds = ps; end
      end
      d = ((mcyc - 1) / R) % 4;
      e_an   = ~(4'b0001 << d);
      e_cat  = m_seg(d, dv, ds);
      e_busy = (cd > 0);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      checks++;
      if (anodo !== e_an || catodo !== e_cat || conv_busy !== e_busy) begin
        errors++;
        $display("FAIL model t=%0t anodo=%b catodo=%b busy=%b want anodo=%b catodo=%b busy=%b",
                 $time, anodo, catodo, conv_busy, e_an, e_cat, e_busy);
      end
    end
  end

  task automatic strobe(input logic la, input logic lb, input logic lm,
                        input logic [3:0] av, input logic [3:0] bv, input logic [7:0] mv);
    @(negedge clk);
    load_a = la; load_b = lb; load_m = lm; a = av; b = bv; m = mv;
    @(negedge clk);
    load_a = 0; load_b = 0; load_m = 0;
  endtask

  task automatic expect_digit(input int d, input logic [6:0] seg, input string nm);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << d);
    n = 0;
    while (anodo !== want && n < 4 * R + 4) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (anodo !== want || catodo !== seg) begin
      errors++;
      $display("FAIL %s anodo=%b catodo=%b want anodo=%b catodo=%b", nm, anodo, catodo, want, seg);
    end
  endtask

  initial begin
    int n;
    rst = 1; load_a = 0; load_b = 0; load_m = 0; a = 0; b = 0; m = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (anodo !== 4'b1111 || catodo !== 7'b1111111) begin
      errors++;
      $display("FAIL reset_out anodo=%b catodo=%b want 1111/1111111", anodo, catodo);
    end
    rst = 0;
    repeat (2) @(negedge clk);
    expect_digit(0, 7'b1000000, "idle_units");
    expect_digit(1, 7'b1111111, "idle_tens");
    expect_digit(2, 7'b1111111, "idle_hund");
    expect_digit(3, 7'b1111111, "idle_src");

    strobe(0, 0, 1, 4'd0, 4'd0, 8'd225);
    n = 0;
    while (conv_busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL busy_len got=%0d want=9", n);
    end
    expect_digit(3, 7'b0001100, "m225_src");
    expect_digit(2, 7'b0100100, "m225_hund");
    expect_digit(1, 7'b0100100, "m225_tens");
    expect_digit(0, 7'b0010010, "m225_units");

    strobe(1, 0, 0, 4'd7, 4'd0, 8'd0);
    repeat (12) @(negedge clk);
    expect_digit(3, 7'b0001000, "a7_src");
    expect_digit(2, 7'b1111111, "a7_hund");
    expect_digit(1, 7'b1111111, "a7_tens");
    expect_digit(0, 7'b1111000, "a7_units");

    strobe(0, 1, 0, 4'd0, 4'd10, 8'd0);
    repeat (12) @(negedge clk);
    expect_digit(3, 7'b0000011, "b10_src");
    expect_digit(2, 7'b1111111, "b10_hund");
    expect_digit(1, 7'b1111001, "b10_tens");
    expect_digit(0, 7'b1000000, "b10_units");

    strobe(1, 0, 1, 4'd5, 4'd0, 8'd100);
    repeat (12) @(negedge clk);
    expect_digit(3, 7'b0001100, "prio_src");
    expect_digit(2, 7'b1111001, "prio_hund");
    expect_digit(1, 7'b1000000, "prio_tens");
    expect_digit(0, 7'b1000000, "prio_units");

    strobe(0, 0, 1, 4'd0, 4'd0, 8'd99);
    repeat (2) @(negedge clk);
    strobe(1, 0, 0, 4'd3, 4'd0, 8'd0);
    repeat (12) @(negedge clk);
    expect_digit(3, 7'b0001000, "restart_src");
    expect_digit(1, 7'b1111111, "restart_tens");
    expect_digit(0, 7'b0110000, "restart_units");

    strobe(0, 0, 1, 4'd0, 4'd0, 8'd144);
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if (conv_busy !== 1'b0 || anodo !== 4'b1111 || catodo !== 7'b1111111) begin
      errors++;
      $display("FAIL midrst busy=%b anodo=%b catodo=%b want 0/1111/1111111", conv_busy, anodo, catodo);
    end
    rst = 0;
    repeat (12) @(negedge clk);
    expect_digit(3, 7'b1111111, "postrst_src");
    expect_digit(0, 7'b1000000, "postrst_units");
    expect_digit(1, 7'b1111111, "postrst_tens");

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
